// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode and direction encodings for the up/down modulo counter
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/count_next_calc.sv
// rtl/count_next_calc.sv - combinational next-count and boundary-crossing calculation
module count_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MOD    = 256,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic              mode,
  output logic [WIDTH-1:0]  count_next,
  output logic              crossing
);

  // One extra bit keeps count+step and count+MOD from truncating.
  localparam logic [WIDTH:0] MOD_C = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MOD - 1);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    count_ext  = {1'b0, count};
    step_ext   = (WIDTH+1)'(step);
    sum        = count_ext + step_ext;
    count_next = count;
    crossing   = 1'b0;
    if (up == DIR_UP) begin
      if (sum <= MAX_C) begin
        count_next = WIDTH'(sum);
      end else begin
        crossing   = 1'b1;
        count_next = (mode == MODE_WRAP) ? WIDTH'(sum - MOD_C) : WIDTH'(MAX_C);
      end
    end else if (up == DIR_DOWN) begin
      if (step_ext <= count_ext) begin
        count_next = WIDTH'(count_ext - step_ext);
      end else begin
        crossing   = 1'b1;
        count_next = (mode == MODE_SAT) ? '0 : WIDTH'(count_ext + MOD_C - step_ext);
      end
    end
  end

endmodule

// File: rtl/up_down_mod_counter.sv
// rtl/up_down_mod_counter.sv - up/down modulo counter with wrap/saturate modes and sticky flags
module up_down_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MOD    = 256,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              udf,
  output logic              at_max,
  output logic              at_zero
);

  localparam logic [WIDTH:0]   MOD_C = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] calc_next;
  logic             calc_cross;
  logic             step_cross;

  count_next_calc #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .STEP_W (STEP_W)
  ) u_calc (
    .count      (count_q),
    .step       (step),
    .up         (up),
    .mode       (mode),
    .count_next (calc_next),
    .crossing   (calc_cross)
  );

  // A crossing only counts when the enabled step is actually taken.
  assign step_cross = enable && !load && calc_cross;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = ({1'b0, load_val} >= MOD_C) ? MAX_W : load_val;
    end else if (enable) begin
      count_d = calc_next;
    end
    tc_d  = step_cross;
    ovf_d = (ovf_q && !clr_flags) || (step_cross && (up == DIR_UP));
    udf_d = (udf_q && !clr_flags) || (step_cross && (up == DIR_DOWN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign at_max  = (count_q == MAX_W);
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// tb/tb_up_down_mod_counter.sv - directed self-checking bench for up_down_mod_counter
module tb_up_down_mod_counter;

  localparam int WIDTH  = 8;
  localparam int MOD    = 200;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              up;
  logic [STEP_W-1:0] step;
  logic              mode;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              tc, ovf, udf, at_max, at_zero;

  int n_vec = 0;
  int n_err = 0;

  up_down_mod_counter #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .STEP_W (STEP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .up        (up),
    .step      (step),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .clr_flags (clr_flags),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf),
    .udf       (udf),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  always #5 clk = ~clk;

  // Stepping by MOD or more is outside the defined operating range.
  always @(posedge clk) begin
    if (!reset && !load && enable) begin
      assert (int'(step) < MOD) else $error("step %0d not below modulus %0d", step, MOD);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input logic t, input logic o, input logic u);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".ovf"},   32'(ovf),   32'(o));
    chk({tag, ".udf"},   32'(udf),   32'(u));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; step = '0; mode = 1'b0;
    load = 1'b0; load_val = '0; clr_flags = 1'b0;
    tick();
    tick();
    chk_state("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset.at_zero", 32'(at_zero), 32'd1);
    chk("reset.at_max",  32'(at_max),  32'd0);

    // count up by one from reset
    reset = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("up1_%0d", i), 32'(count), 32'(i));
      chk($sformatf("up1_%0d.tc", i), 32'(tc), 32'd0);
      chk($sformatf("up1_%0d.ovf", i), 32'(ovf), 32'd0);
    end

    // wrap up through the boundary, then wrap down
    enable = 1'b0; load = 1'b1; load_val = 8'd198;
    tick();
    chk_state("load198", 198, 1'b0, 1'b0, 1'b0);
    load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd3;
    tick();
    chk_state("wrap_up", 1, 1'b1, 1'b1, 1'b0);
    up = 1'b0; step = 4'd5;
    tick();
    chk_state("wrap_dn", 196, 1'b1, 1'b1, 1'b1);
    enable = 1'b0;
    tick();
    chk_state("hold", 196, 1'b0, 1'b1, 1'b1);

    // clear flags, then saturate down and hold at zero
    clr_flags = 1'b1;
    tick();
    chk_state("clr", 196, 1'b0, 1'b0, 1'b0);
    clr_flags = 1'b0; mode = 1'b1; load = 1'b1; load_val = 8'd2;
    tick();
    chk_state("load2", 2, 1'b0, 1'b0, 1'b0);
    load = 1'b0; enable = 1'b1; up = 1'b0; step = 4'd4;
    tick();
    chk_state("sat_dn", 0, 1'b1, 1'b0, 1'b1);
    chk("sat_dn.at_zero", 32'(at_zero), 32'd1);
    tick();
    chk_state("sat_dn_hold", 0, 1'b1, 1'b0, 1'b1);

    // load beats enable and clamps to MOD-1
    load = 1'b1; load_val = 8'd250; up = 1'b1; step = 4'd4;
    tick();
    chk_state("load250", 199, 1'b0, 1'b0, 1'b1);
    chk("load250.at_max", 32'(at_max), 32'd1);

    // saturated hold at max with clr_flags: crossing wins for ovf
    load = 1'b0; step = 4'd1; clr_flags = 1'b1;
    tick();
    chk_state("sat_up_clr", 199, 1'b1, 1'b1, 1'b0);

    // wrap from max to zero, then step 0 holds
    clr_flags = 1'b0; mode = 1'b0;
    tick();
    chk_state("wrap_max", 0, 1'b1, 1'b1, 1'b0);
    step = 4'd0;
    tick();
    chk_state("step0", 0, 1'b0, 1'b1, 1'b0);
    up = 1'b0;
    tick();
    chk_state("step0_dn", 0, 1'b0, 1'b1, 1'b0);

    // wrap down from zero
    step = 4'd1;
    tick();
    chk_state("wrap_dn0", 199, 1'b1, 1'b1, 1'b1);

    // reset mid-count discards everything
    enable = 1'b0; load = 1'b1; load_val = 8'd150;
    tick();
    chk("load150", 32'(count), 32'd150);
    load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd2; reset = 1'b1; clr_flags = 1'b0;
    tick();
    chk_state("rst_mid", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_%0d", i), 32'(count), 32'd0);
    end
    enable = 1'b1;
    tick();
    chk_state("resume", 2, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
